bitcell_array_ctrl: RTL and testbench

Sequential access controller that sits directly upstream of the team's 1-bit latch memory cells (cs / wr_data / rd_wr in, rd_data out). It turns a clocked valid/ready word request into cell-level strobe sequences for a DEPTH x WIDTH array of those cells. Each word row is one cs line. All bits of a row share rd_wr, and each bit column has its own wr_data. The row's rd_data bits are returned muxed onto rd_data. The sequence is the one the cells require: data and direction are set up first, cs is pulsed, then cs is released before direction changes.

---
 rtl/bitcell_array_ctrl.sv | 121 ++++++++++++
 tb/tb_bitcell_array_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitcell_array_ctrl.sv
// Word-level valid/ready front end for a DEPTH x WIDTH array of 1-bit latch cells.
// Sequences setup -> cs pulse -> recover so direction and data never move while a row is selected.
module bitcell_array_ctrl #(
  parameter int WIDTH   = 8,
  parameter int AW      = 2,
  parameter int ACC_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [AW-1:0]      req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  output logic               resp_valid,
  output logic [WIDTH-1:0]   resp_rdata,
  output logic [(2**AW)-1:0] cs,
  output logic               rd_wr,
  output logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH-1:0]   rd_data
);

  localparam int DEPTH = 2**AW;
  localparam int CW    = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_ACCESS  = 2'd2,
    S_RECOVER = 2'd3
  } state_e;

  state_e           state_q;
  logic             ready_q;
  logic             write_q;
  logic [AW-1:0]    addr_q;
  logic [CW-1:0]    cnt_q;
  logic [DEPTH-1:0] cs_q;
  logic             rd_wr_q;
  logic [WIDTH-1:0] wr_data_q;
  logic             resp_valid_q;
  logic [WIDTH-1:0] resp_rdata_q;

  // Direction and write data are launched on the accept edge so they are settled for the whole SETUP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= {AW{1'b0}};
      cnt_q        <= {CW{1'b0}};
      cs_q         <= {DEPTH{1'b0}};
      rd_wr_q      <= 1'b1;
      wr_data_q    <= {WIDTH{1'b0}};
      resp_valid_q <= 1'b0;
      resp_rdata_q <= {WIDTH{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          cs_q         <= {DEPTH{1'b0}};
          resp_valid_q <= 1'b0;
          if (ready_q && req_valid) begin
            ready_q <= 1'b0;
            write_q <= req_write;
            addr_q  <= req_addr;
            rd_wr_q <= ~req_write;
            cnt_q   <= CW'(ACC_CYC - 1);
            if (req_write) begin
              wr_data_q <= req_wdata;
            end else begin
              wr_data_q <= wr_data_q;
            end
            state_q <= S_SETUP;
          end else begin
            ready_q <= 1'b1;
            rd_wr_q <= 1'b1;
          end
        end
        S_SETUP: begin
          cs_q    <= {{(DEPTH-1){1'b0}}, 1'b1} << addr_q;
          state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          if (cnt_q == {CW{1'b0}}) begin
            cs_q    <= {DEPTH{1'b0}};
            state_q <= S_RECOVER;
            if (!write_q) begin
              resp_rdata_q <= rd_data;
              resp_valid_q <= 1'b1;
            end else begin
              resp_valid_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_RECOVER: begin
          resp_valid_q <= 1'b0;
          rd_wr_q      <= 1'b1;
          ready_q      <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q      <= S_IDLE;
          ready_q      <= 1'b0;
          cs_q         <= {DEPTH{1'b0}};
          rd_wr_q      <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign cs         = cs_q;
  assign rd_wr      = rd_wr_q;
  assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// Bench for bitcell_array_ctrl: behavioral cell array, per-phase strobe checks and a read-data scoreboard.
module tb_bitcell_array_ctrl;

  localparam int WIDTH = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 2**AW;
  localparam int ACC   = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_rdata;
  logic [DEPTH-1:0] cs;
  logic             rd_wr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int n_acc  = 0;
  int viol   = 0;

  logic [WIDTH-1:0] cell_mem [DEPTH];
  logic [WIDTH-1:0] ref_mem  [DEPTH];
  logic [WIDTH-1:0] exp_q [$];

  bitcell_array_ctrl #(.WIDTH(WIDTH), .AW(AW), .ACC_CYC(ACC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .cs         (cs),
    .rd_wr      (rd_wr),
    .wr_data    (wr_data),
    .rd_data    (rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Cell array: selected row stores wr_data while rd_wr is low; rd_data muxed by cs.
  initial for (int r = 0; r < DEPTH; r++) cell_mem[r] = 8'h00;
  always @(posedge clk) begin
    for (int r = 0; r < DEPTH; r++)
      if (cs[r] && !rd_wr) cell_mem[r] <= wr_data;
  end
  always_comb begin
    rd_data = 8'h00;
    for (int r = 0; r < DEPTH; r++)
      if (cs[r]) rd_data = rd_data | cell_mem[r];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [DEPTH-1:0] onehot(input logic [AW-1:0] a);
    logic [DEPTH-1:0] v;
    v = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  // Scoreboard: every resp_valid pops the oldest expected read word.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (exp_q.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
      else check("rdata", 32'(resp_rdata), 32'(exp_q.pop_front()));
    end
  end

  // Accept counter plus stability / one-hot monitor.
  logic             have_prev = 1'b0;
  logic [DEPTH-1:0] prev_cs;
  logic             prev_rdwr;
  logic [WIDTH-1:0] prev_wd;
  always @(negedge clk) begin
    if (!rst_n) begin
      have_prev = 1'b0;
    end else begin
      if (req_valid && req_ready) n_acc++;
      if (have_prev && (cs != '0 || prev_cs != '0) &&
          (rd_wr != prev_rdwr || wr_data != prev_wd)) viol++;
      if ($countones(cs) > 1) viol++;
      prev_cs   = cs;
      prev_rdwr = rd_wr;
      prev_wd   = wr_data;
      have_prev = 1'b1;
    end
  end

  task automatic push_expect(input logic wr, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    if (wr) ref_mem[a] = d;
    else exp_q.push_back(ref_mem[a]);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_access(input logic wr, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    bit ok;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    wait_ready(ok);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = ~d;
    if (ok) push_expect(wr, a, d);
    for (int i = 0; i <= ACC + 2; i++) begin
      @(negedge clk);
      check("cs", 32'(cs), (i >= 1 && i <= ACC) ? 32'(onehot(a)) : 32'd0);
      check("rd_wr", 32'(rd_wr), (i == ACC + 2) ? 32'd1 : 32'(!wr));
      check("req_ready", 32'(req_ready), (i == ACC + 2) ? 32'd1 : 32'd0);
      if (i == 0 && wr) check("setup_wr_data", 32'(wr_data), 32'(d));
      if (i == ACC + 1) check("resp_valid", 32'(resp_valid), 32'(!wr));
      else check("resp_valid_idle", 32'(resp_valid), 32'd0);
    end
  endtask

  task automatic back_to_back();
    bit ok;
    int t_acc [3];
    logic          wrs [3];
    logic [AW-1:0] ads [3];
    logic [7:0]    dts [3];
    int acc0;
    wrs[0] = 1'b1; ads[0] = 2'd1; dts[0] = 8'h5A;
    wrs[1] = 1'b0; ads[1] = 2'd1; dts[1] = 8'h00;
    wrs[2] = 1'b1; ads[2] = 2'd2; dts[2] = 8'hC3;
    acc0 = n_acc;
    @(posedge clk); #1;
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_write = wrs[k]; req_addr = ads[k]; req_wdata = dts[k];
      wait_ready(ok);
      t_acc[k] = cyc;
      @(posedge clk); #1;
      if (ok) push_expect(wrs[k], ads[k], dts[k]);
    end
    req_valid = 1'b0;
    repeat (ACC + 3) @(negedge clk);
    check("b2b_accepts", 32'(n_acc - acc0), 32'd3);
    check("b2b_space01", 32'(t_acc[1] - t_acc[0]), 32'(ACC + 3));
    check("b2b_space12", 32'(t_acc[2] - t_acc[1]), 32'(ACC + 3));
  endtask

  initial begin
    bit ok;
    for (int r = 0; r < DEPTH; r++) ref_mem[r] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    #12;
    check("rst_cs", 32'(cs), 32'd0);
    check("rst_rd_wr", 32'(rd_wr), 32'd1);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    #10;
    rst_n = 1'b1;
    #1;
    check("ready_at_release", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("ready_after_release", 32'(req_ready), 32'd1);

    do_access(1'b1, 2'd2, 8'hA5);
    do_access(1'b0, 2'd2, 8'h00);
    do_access(1'b1, 2'd3, 8'h3C);
    do_access(1'b0, 2'd0, 8'h00);
    do_access(1'b0, 2'd3, 8'h00);
    back_to_back();
    do_access(1'b0, 2'd2, 8'h00);

    // Abort a read while its row is selected; no response must follow.
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd1;
    wait_ready(ok);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_cs_high", 32'(cs), 32'(onehot(2'd1)));
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_cs", 32'(cs), 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd0);
    check("abort_rd_wr", 32'(rd_wr), 32'd1);
    check("abort_wr_data", 32'(wr_data), 32'd0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    do_access(1'b0, 2'd3, 8'h00);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("stability_violations", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
